fetch_sequencer: RTL

- Owns the program counter and sequences instruction fetch for the pipelined core.
- Predicts each fetch with a direct-mapped branch target buffer (BTB) holding 2-bit saturating counters.
- Takes branch/jump resolution from the ID stage (branch condition, computed target), redirects the PC on a misprediction and squashes the wrong-path IF instruction.
- Sits between the hazard unit and the IF/ID pipeline register.

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_sequencer_btb.sv | 119 +++++++++++
 rtl/fetch_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared defaults and BTB encodings for the fetch sequencer.
// Optional FETCH_SEQ_STATS_EN adds branch/mispredict statistics counters to the top.
package fetch_sequencer_pkg;

    localparam int WORD_SIZE_DEF    = 16;
    localparam int BTB_IDX_BITS_DEF = 4;
    localparam int RESET_PC_DEF     = 0;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // What a resolved branch does to its BTB entry.
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_TRAIN = 2'd1,
        UPD_ALLOC = 2'd2
    } upd_kind_e;

endpackage

// File: rtl/fetch_sequencer_btb.sv
// Direct-mapped branch target buffer: async-read lookup, synchronous update with
// 2-bit saturating counters. Valid bits and counters reset; tags/targets do not.
module fetch_sequencer_btb
    import fetch_sequencer_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int IDX_BITS  = BTB_IDX_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] lookup_pc,
    output logic                 lookup_hit,
    output logic [1:0]           lookup_ctr,
    output logic [WORD_SIZE-1:0] lookup_target,
    input  logic                 upd_en,
    input  logic                 upd_is_jump,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = WORD_SIZE - IDX_BITS;

    logic                 valid   [ENTRIES];
    logic [1:0]           ctrs    [ENTRIES];
    logic [TAG_W-1:0]     tags    [ENTRIES];
    logic [WORD_SIZE-1:0] targets [ENTRIES];

    logic [IDX_BITS-1:0]  l_idx;
    logic [TAG_W-1:0]     l_tag;
    logic [IDX_BITS-1:0]  u_idx;
    logic [TAG_W-1:0]     u_tag;
    logic                 u_hit;
    upd_kind_e            upd_kind;
    logic [1:0]           ctr_new;
    logic                 write_target;

    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

    // Lookup port: reads pre-update contents, so a same-cycle write shows up next cycle.
    assign l_idx         = lookup_pc[IDX_BITS-1:0];
    assign l_tag         = lookup_pc[WORD_SIZE-1:IDX_BITS];
    assign lookup_hit    = valid[l_idx] && (tags[l_idx] == l_tag);
    assign lookup_ctr    = ctrs[l_idx];
    assign lookup_target = targets[l_idx];

    assign u_idx = upd_pc[IDX_BITS-1:0];
    assign u_tag = upd_pc[WORD_SIZE-1:IDX_BITS];
    assign u_hit = valid[u_idx] && (tags[u_idx] == u_tag);

    always_comb begin
        upd_kind = UPD_NONE;
        if (upd_en) begin
            if (u_hit) begin
                upd_kind = UPD_TRAIN;
            end else if (upd_taken) begin
                upd_kind = UPD_ALLOC;
            end
        end
    end

    always_comb begin
        ctr_new      = ctrs[u_idx];
        write_target = 1'b0;
        case (upd_kind)
            UPD_TRAIN: begin
                if (upd_is_jump) begin
                    ctr_new      = CTR_ST;
                    write_target = 1'b1;
                end else if (upd_taken) begin
                    ctr_new      = ctr_sat_inc(ctrs[u_idx]);
                    write_target = 1'b1;
                end else begin
                    ctr_new      = ctr_sat_dec(ctrs[u_idx]);
                end
            end
            UPD_ALLOC: begin
                ctr_new      = upd_is_jump ? CTR_ST : CTR_WT;
                write_target = 1'b1;
            end
            default: begin
                ctr_new      = ctrs[u_idx];
                write_target = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctrs[i]  <= CTR_WNT;
            end
        end else if (upd_kind != UPD_NONE) begin
            ctrs[u_idx] <= ctr_new;
            if (upd_kind == UPD_ALLOC) begin
                valid[u_idx] <= 1'b1;
            end
        end
    end

    // Tag/target storage is gated by the valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (upd_kind == UPD_ALLOC) begin
            tags[u_idx] <= u_tag;
        end
        if (write_target) begin
            targets[u_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, BTB-predicted next-PC selection and ID-stage misprediction redirect.
// Define FETCH_SEQ_STATS_EN to add saturating stat_branches / stat_mispredicts outputs.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                   WORD_SIZE    = WORD_SIZE_DEF,
    parameter int                   BTB_IDX_BITS = BTB_IDX_BITS_DEF,
    parameter logic [WORD_SIZE-1:0] RESET_PC     = WORD_SIZE'(RESET_PC_DEF)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    output logic [WORD_SIZE-1:0] if_pc,
    output logic                 if_pred_taken,
    output logic [WORD_SIZE-1:0] if_pred_target,
    output logic                 flush_if,
    input  logic                 id_valid,
    input  logic                 id_is_branch,
    input  logic                 id_is_jump,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic                 id_taken,
    input  logic [WORD_SIZE-1:0] id_target,
    input  logic                 id_pred_taken,
    input  logic [WORD_SIZE-1:0] id_pred_target
`ifdef FETCH_SEQ_STATS_EN
    ,
    output logic [15:0]          stat_branches,
    output logic [15:0]          stat_mispredicts
`endif
);

    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pc_next;
    logic [WORD_SIZE-1:0] pc_inc;
    logic [WORD_SIZE-1:0] id_pc_inc;
    logic                 btb_hit;
    logic [1:0]           btb_ctr;
    logic [WORD_SIZE-1:0] btb_target;
    logic                 resolve;
    logic                 mispredict;

    fetch_sequencer_btb #(
        .WORD_SIZE (WORD_SIZE),
        .IDX_BITS  (BTB_IDX_BITS)
    ) u_btb (
        .clk           (clk),
        .reset_n       (reset_n),
        .lookup_pc     (pc),
        .lookup_hit    (btb_hit),
        .lookup_ctr    (btb_ctr),
        .lookup_target (btb_target),
        .upd_en        (resolve),
        .upd_is_jump   (id_is_jump),
        .upd_taken     (id_taken),
        .upd_pc        (id_pc),
        .upd_target    (id_target)
    );

    assign if_pc          = pc;
    assign if_pred_taken  = btb_hit && btb_ctr[1];
    assign if_pred_target = btb_hit ? btb_target : '0;

    // ID resolution is frozen while the hazard unit stalls; it re-resolves afterwards.
    assign resolve    = id_valid && !stall && (id_is_branch || id_is_jump);
    assign mispredict = resolve &&
                        ((id_taken != id_pred_taken) ||
                         (id_taken && (id_target != id_pred_target)));
    assign flush_if   = mispredict;

    assign pc_inc    = pc + WORD_SIZE'(1);
    assign id_pc_inc = id_pc + WORD_SIZE'(1);

    always_comb begin
        pc_next = pc_inc;
        if (mispredict) begin
            pc_next = id_taken ? id_target : id_pc_inc;
        end else if (stall) begin
            pc_next = pc;
        end else if (if_pred_taken) begin
            pc_next = if_pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef FETCH_SEQ_STATS_EN
    function automatic logic [15:0] stat_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= 16'd0;
            stat_mispredicts <= 16'd0;
        end else begin
            if (resolve) begin
                stat_branches <= stat_sat_inc(stat_branches);
            end
            if (mispredict) begin
                stat_mispredicts <= stat_sat_inc(stat_mispredicts);
            end
        end
    end
`endif

endmodule
